// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam int   PS2_DATA_BITS  = 8;
    localparam logic PS2_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises and deglitches the raw PS/2 clock; emits a one-cycle strobe
// on each filtered high-to-low transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  w_all0;
    logic                  w_all1;

    assign w_all0 = ~|r_hist;
    assign w_all1 = &r_hist;

    // Level only moves when the whole window agrees, so short pulses never reach it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= {2{PS2_IDLE_LEVEL}};
            r_hist  <= {FILTER_LEN{PS2_IDLE_LEVEL}};
            r_level <= PS2_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
            if (w_all0)
                r_level <= 1'b0;
            else if (w_all1)
                r_level <= 1'b1;
        end
    end

    assign o_fall = r_level & w_all0;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity,
// stop. Delivers a byte with a done strobe, or an error strobe on bad/stalled frames.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_US  = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_done,
    output logic                     rx_err
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    ps2_rx_state_t            r_state, w_state_nxt;
    logic [1:0]               r_dsync;
    logic [2:0]               r_bitcnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic                     r_par;
    logic [TO_W-1:0]          r_to;
    logic [PS2_DATA_BITS-1:0] r_rx_data;
    logic                     r_done;
    logic                     r_err;

    logic                     w_fall;
    logic                     w_bit;
    logic                     w_timeout;
    logic                     w_step;
    logic                     w_par_ok;
    logic [TO_W-1:0]          w_to_cur;
    logic                     w_done_nxt;
    logic                     w_err_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .rst    (rst),
        .i_line (ps2_clk),
        .o_fall (w_fall)
    );

    assign w_bit     = r_dsync[1];
    assign w_par_ok  = ^{r_shift, r_par};
    assign w_timeout = (r_state != IDLE) && (r_to == TO_W'(TIMEOUT_CYCLES));
    assign w_step    = w_fall & ~w_timeout;
    // r_to counts cycles since the last fall, the fall cycle itself being zero.
    assign w_to_cur  = w_fall ? '0 : r_to;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE:   if (!w_bit) w_state_nxt = DATA;
                DATA:   if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = PARITY;
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_bit && w_par_ok)
                        w_done_nxt = 1'b1;
                    else
                        w_err_nxt = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dsync   <= {2{PS2_IDLE_LEVEL}};
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to      <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_dsync <= {r_dsync[0], ps2_data};
            r_to    <= (w_state_nxt == IDLE) ? '0 : w_to_cur + TO_W'(1);
            if (w_step) begin
                if (r_state == IDLE)
                    r_bitcnt <= '0;
                if (r_state == DATA) begin
                    r_shift  <= {w_bit, r_shift[PS2_DATA_BITS-1:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                if (r_state == PARITY)
                    r_par <= w_bit;
            end
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (w_done_nxt)
                r_rx_data <= r_shift;
        end
    end

    assign rx_data = r_rx_data;
    assign rx_done = r_done;
    assign rx_err  = r_err;

endmodule
